// File: rtl/rbm_gemv_engine.sv
// RBM visible->hidden GEMV engine: LANES hidden units per group accumulate v*w over
// the visible vector, then a hard-sigmoid gives probabilities or LFSR-sampled bits.
module rbm_gemv_engine #(
  parameter int          I_DIM     = 256,
  parameter int          H_DIM     = 64,
  parameter int          LANES     = 4,
  parameter int          ACC_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         GROUPS    = H_DIM / LANES,
  localparam int         IW        = $clog2(I_DIM),
  localparam int         GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int         HW        = $clog2(H_DIM),
  localparam int         LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sample_en,
  output logic                     busy,
  output logic                     done,
  output logic [IW-1:0]            v_addr,
  input  logic [7:0]               v_data,
  output logic [GW+IW-1:0]         w_addr,
  input  logic [16*LANES-1:0]      w_data,
  output logic [GW-1:0]            b_addr,
  input  logic [ACC_W*LANES-1:0]   b_data,
  output logic                     p_valid,
  input  logic                     p_ready,
  output logic [15:0]              p_data,
  output logic [HW-1:0]            p_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BIAS  = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [2:0]              state;
  logic [GW-1:0]           g;
  logic [IW-1:0]           i;
  logic [LW-1:0]           lane;
  logic                    smp;
  logic                    done_q;
  logic [15:0]             lfsr;
  logic [15:0]             lfsr_nxt;
  logic                    first_acc;
  logic [15:0]             sel_prob;
  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];
  logic [15:0]             act_nxt [LANES];
  logic [15:0]             prob    [LANES];

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0] base,
                                                  input logic signed [7:0]       v,
                                                  input logic signed [15:0]      w);
    logic signed [23:0] prod;
    prod = v * w;
    return sat_add(base, ACC_W'(prod));
  endfunction

  // Hard sigmoid 0.5 + x/4 in Q0.16, clamped to [0, 65535].
  function automatic logic [15:0] hsig(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = {a[ACC_W-1], a};
    t = (t >>> 8) + (ACC_W+1)'(32768);
    if (t[ACC_W]) return 16'h0000;
    if (|t[ACC_W-1:16]) return 16'hFFFF;
    return t[15:0];
  endfunction

  // The pair arriving in the first ACC cycle belongs to i=0 and is added onto the bias.
  assign first_acc = (state == S_ACC) && (i == IW'(1));

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      acc_nxt[l] = mac(first_acc ? $signed(b_data[ACC_W*l +: ACC_W]) : acc[l],
                       v_data, w_data[16*l +: 16]);
      act_nxt[l] = hsig(acc_nxt[l]);
    end
  end

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign sel_prob = prob[lane];

  assign busy    = (state != S_IDLE);
  assign p_valid = (state == S_OUT);
  assign done    = done_q;
  assign v_addr  = i;
  assign w_addr  = {g, i};
  assign b_addr  = g;
  assign p_data  = smp ? ((sel_prob > lfsr) ? 16'hFFFF : 16'h0000) : sel_prob;
  assign p_idx   = HW'(int'(g) * LANES + int'(lane));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values no matter the statement order below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      g      <= '0;
      i      <= '0;
      lane   <= '0;
      smp    <= 1'b0;
      done_q <= 1'b0;
      lfsr   <= LFSR_SEED;
      // NOTE: acc and prob are small flop banks, not RAM, so they take the reset too.
      for (int l = 0; l < LANES; l++) begin
        acc[l]  <= '0;
        prob[l] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_BIAS;
            g     <= '0;
            i     <= '0;
            lane  <= '0;
            smp   <= sample_en;
          end
        end
        S_BIAS: begin
          state <= S_ACC;
          i     <= IW'(1);
        end
        S_ACC: begin
          acc <= acc_nxt;
          if (i == IW'(I_DIM - 1)) state <= S_FLUSH;
          else                     i     <= i + IW'(1);
        end
        S_FLUSH: begin
          acc   <= acc_nxt;
          prob  <= act_nxt;
          lane  <= '0;
          state <= S_OUT;
        end
        S_OUT: begin
          if (p_ready) begin
            lfsr <= lfsr_nxt;
            if (lane == LW'(LANES - 1)) begin
              lane <= '0;
              if (g == GW'(GROUPS - 1)) begin
                state  <= S_IDLE;
                done_q <= 1'b1;
              end else begin
                g     <= g + GW'(1);
                i     <= '0;
                state <= S_BIAS;
              end
            end else begin
              lane <= lane + LW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_gemv_engine.sv
// Directed bench for rbm_gemv_engine: a small 4x8 instance with modelled memories and
// a 256-deep 24-bit instance fed constant worst-case operands for saturation.
module tb_rbm_gemv_engine;

  localparam int AI = 4, AH = 8, AL = 4, AACC = 32;
  localparam int BI = 256, BH = 4, BL = 4, BACC = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A signals
  logic         start_a, smp_a, busy_a, done_a, p_valid_a, p_ready_a;
  logic [1:0]   v_addr_a;
  logic [7:0]   v_data_a;
  logic [2:0]   w_addr_a;
  logic [63:0]  w_data_a;
  logic [0:0]   b_addr_a;
  logic [127:0] b_data_a;
  logic [15:0]  p_data_a;
  logic [2:0]   p_idx_a;

  // Instance B signals
  logic         start_b, busy_b, done_b, p_valid_b, p_ready_b;
  logic [7:0]   v_addr_b;
  logic [7:0]   v_data_b;
  logic [8:0]   w_addr_b;
  logic [63:0]  w_data_b;
  logic [0:0]   b_addr_b;
  logic [95:0]  b_data_b;
  logic [15:0]  p_data_b;
  logic [1:0]   p_idx_b;

  assign v_data_b = 8'h80;
  assign w_data_b = {4{16'h8000}};
  assign b_data_b = '0;

  rbm_gemv_engine #(.I_DIM(AI), .H_DIM(AH), .LANES(AL), .ACC_W(AACC), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sample_en(smp_a), .busy(busy_a), .done(done_a),
    .v_addr(v_addr_a), .v_data(v_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .b_addr(b_addr_a), .b_data(b_data_a), .p_valid(p_valid_a), .p_ready(p_ready_a),
    .p_data(p_data_a), .p_idx(p_idx_a)
  );

  rbm_gemv_engine #(.I_DIM(BI), .H_DIM(BH), .LANES(BL), .ACC_W(BACC), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sample_en(1'b0), .busy(busy_b), .done(done_b),
    .v_addr(v_addr_b), .v_data(v_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .b_addr(b_addr_b), .b_data(b_data_b), .p_valid(p_valid_b), .p_ready(p_ready_b),
    .p_data(p_data_b), .p_idx(p_idx_b)
  );

  // Memory model for A: one-cycle read latency; w_addr = {group, i}.
  logic [7:0]         v_mem [4];
  logic [15:0]        w_mem [2][4][4];
  logic signed [31:0] b_mem [2][4];

  always @(posedge clk) begin
    v_data_a <= v_mem[v_addr_a];
    for (int l = 0; l < 4; l++) begin
      w_data_a[16*l +: 16] <= w_mem[w_addr_a[2]][w_addr_a[1:0]][l];
      b_data_a[32*l +: 32] <= b_mem[b_addr_a][l];
    end
  end

  int checks = 0;
  int errors = 0;
  int dones_a = 0;

  always @(negedge clk) if (done_a === 1'b1) dones_a++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Wait for an output word on A, check it (optionally across a stall), then accept it.
  task automatic recv_a(input int exp_idx, input int exp_data, input int stall, input string tag);
    int n;
    n = 0;
    while (p_valid_a !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s valid %0d", tag, exp_idx), 32'(p_valid_a), 1);
    check($sformatf("%s idx %0d", tag, exp_idx), 32'(p_idx_a), exp_idx);
    check($sformatf("%s data %0d", tag, exp_idx), 32'(p_data_a), exp_data);
    if (stall > 0) begin
      p_ready_a = 1'b0;
      repeat (stall) @(negedge clk);
      check($sformatf("%s stall valid %0d", tag, exp_idx), 32'(p_valid_a), 1);
      check($sformatf("%s stall idx %0d", tag, exp_idx), 32'(p_idx_a), exp_idx);
      check($sformatf("%s stall data %0d", tag, exp_idx), 32'(p_data_a), exp_data);
    end
    p_ready_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic pass_end_a(input string tag, input int dones_before);
    check({tag, " done pulse"}, 32'(done_a), 1);
    check({tag, " idle"}, 32'(busy_a), 0);
    @(negedge clk);
    check({tag, " done single"}, 32'(done_a), 0);
    check({tag, " done count"}, 32'(dones_a), dones_before + 1);
  endtask

  task automatic start_pass_a(input logic smp);
    smp_a   = smp;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    smp_a   = 1'b0;
  endtask

  int          n;
  int          d0;
  logic [15:0] lf;
  int          exp2 [8] = '{0, 65535, 40448, 33072, 33768, 31768, 65535, 0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; smp_a = 1'b0; p_ready_a = 1'b0;
    start_b = 1'b0; p_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) v_mem[i] = 8'h40;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 4; i++)
        for (int l = 0; l < 4; l++) begin
          w_mem[g][i][l] = 16'h4000;
          b_mem[g][l]    = 32'sd0;
        end
    repeat (2) @(negedge clk);

    // Reset state
    check("rst busy", 32'(busy_a), 0);
    check("rst done", 32'(done_a), 0);
    check("rst p_valid", 32'(p_valid_a), 0);
    check("rst p_data", 32'(p_data_a), 0);
    check("rst p_idx", 32'(p_idx_a), 0);
    check("rst v_addr", 32'(v_addr_a), 0);
    check("rst w_addr", 32'(w_addr_a), 0);
    check("rst b_addr", 32'(b_addr_a), 0);
    check("rst busy b", 32'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);

    // Uniform 0.5 x 0.5 over 4 inputs: acc = 4*2^20, p = 49152; latency and start-while-busy
    d0 = dones_a;
    p_ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    n = 1;
    start_a = 1'b0;
    check("t1 busy", 32'(busy_a), 1);
    check("t1 bias b_addr", 32'(b_addr_a), 0);
    check("t1 bias w_addr", 32'(w_addr_a), 0);
    @(negedge clk);
    n++;
    start_a = 1'b1;
    @(negedge clk);
    n++;
    start_a = 1'b0;
    while (p_valid_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1 latency", 32'(n), AI + 2);
    for (int k = 0; k < 8; k++) recv_a(k, 49152, 0, "t1");
    pass_end_a("t1", d0);

    // Clamp at both ends, order-dependent products, p_ready toggling
    v_mem[0] = 8'h10; v_mem[1] = 8'h20; v_mem[2] = 8'h40; v_mem[3] = 8'h08;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 4; i++)
        for (int l = 0; l < 4; l++) w_mem[g][i][l] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      w_mem[0][i][2] = 16'h4000;
      w_mem[0][i][3] = 16'(256 * (i + 1));
    end
    b_mem[0] = '{-(32'sd1 <<< 24), (32'sd1 <<< 24), 32'sd0, 32'sd0};
    b_mem[1] = '{32'sd256000, -32'sd256000, 32'sd8388352, -32'sd8388608};
    d0 = dones_a;
    start_pass_a(1'b0);
    for (int k = 0; k < 8; k++) recv_a(k, exp2[k], 2, "t2");
    pass_end_a("t2", d0);

    // Sample mode with p fixed at 32768, LFSR from seed, occasional stalls
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) v_mem[i] = 8'h00;
    for (int g = 0; g < 2; g++)
      for (int l = 0; l < 4; l++) b_mem[g][l] = 32'sd0;
    lf = 16'hACE1;
    d0 = dones_a;
    start_pass_a(1'b1);
    for (int k = 0; k < 8; k++) begin
      recv_a(k, (32768 > int'(lf)) ? 65535 : 0, k % 2, "t3");
      lf = lfsr_step(lf);
    end
    pass_end_a("t3", d0);

    // Reset in ACC of group 1 abandons the pass; the next pass restarts from scratch
    d0 = dones_a;
    start_pass_a(1'b1);
    for (int k = 0; k < 4; k++) begin
      recv_a(k, (32768 > int'(lf)) ? 65535 : 0, 0, "t4a");
      lf = lfsr_step(lf);
    end
    @(negedge clk);
    check("t4 group1 busy", 32'(busy_a), 1);
    check("t4 group1 b_addr", 32'(b_addr_a), 1);
    rst = 1'b1;
    #1;
    check("t4 rst busy", 32'(busy_a), 0);
    check("t4 rst p_valid", 32'(p_valid_a), 0);
    check("t4 rst b_addr", 32'(b_addr_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t4 no spurious done", 32'(dones_a), d0);
    lf = 16'hACE1;
    start_pass_a(1'b1);
    for (int k = 0; k < 8; k++) begin
      recv_a(k, (32768 > int'(lf)) ? 65535 : 0, 0, "t4b");
      lf = lfsr_step(lf);
    end
    pass_end_a("t4b", d0);

    // Instance B: 256 products of 2^22 saturate a 24-bit accumulator at 2^23-1 -> 65535
    p_ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    n = 1;
    start_b = 1'b0;
    while (p_valid_b !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5 latency", 32'(n), BI + 2);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (p_valid_b !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("t5 idx %0d", k), 32'(p_idx_b), k);
      check($sformatf("t5 data %0d", k), 32'(p_data_b), 65535);
      @(negedge clk);
    end
    check("t5 done", 32'(done_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rbm_gemv_engine.md
RBM_GEMV_ENGINE -- requirements
Module: rbm_gemv_engine

Interface
REQ-001 SHALL have parameter I_DIM, default 256, visible-vector length (>=2).
REQ-002 SHALL have parameter H_DIM, default 64, hidden-unit count (multiple of LANES).
REQ-003 SHALL have parameter LANES, default 4, hidden units computed in parallel.
REQ-004 SHALL have parameter ACC_W, default 32, accumulator width (>=24).
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero sampler seed.
REQ-006 SHALL have one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  async active-high reset.
REQ-009 start  in  1  begin full-layer pass; sampled only in IDLE.
REQ-010 sample_en  in  1  1 = Bernoulli-sampled output, 0 = probability output; latched at start.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 done  out  1  one-cycle pulse after the last output handshake.
REQ-013 v_addr  out  $clog2(I_DIM)  visible-memory read address.
REQ-014 v_data  in  8  signed Q1.7, valid one cycle after v_addr.
REQ-015 w_addr  out  $clog2(I_DIM)+$clog2(H_DIM/LANES)  weight address {group, i}.
REQ-016 w_data  in  16*LANES  signed Q1.15 per lane (lane 0 = LSBs), valid one cycle after w_addr.
REQ-017 b_addr  out  $clog2(H_DIM/LANES)  bias address (group index).
REQ-018 b_data  in  ACC_W*LANES  signed Q.22 biases, valid one cycle after b_addr.
REQ-019 p_valid  out  1  output word valid.
REQ-020 p_ready  in  1  downstream accept.
REQ-021 p_data  out  16  unsigned Q0.16 probability, or sample 0/65535.
REQ-022 p_idx  out  $clog2(H_DIM)  hidden index of p_data.

Function
REQ-023 FSM states SHALL be IDLE, BIAS, ACC, FLUSH, OUT; group counter g counts 0..H_DIM/LANES-1.
REQ-024 IDLE with start=1 SHALL go to BIAS with g=0, i=0, latch sample_en; start while busy SHALL be ignored.
REQ-025 BIAS (1 cycle) SHALL drive b_addr=g, v_addr=0, w_addr={g,0}, then go to ACC.
REQ-026 ACC SHALL issue addresses i=1..I_DIM-1 over I_DIM-1 cycles; first ACC cycle loads acc[l]<=b_data lane l and the cycle's returning data pair is ignored except per REQ-027.
REQ-027 Each returning (v_data, w_data) pair for i=0..I_DIM-1 SHALL be added exactly once: prod = v*w (24-bit signed), sign-extended to ACC_W, saturating add (clamp to signed ACC_W min/max); last pair added in FLUSH.
REQ-028 First ACC cycle SHALL load bias plus product of i=0 (pair returned from BIAS addresses).
REQ-029 FLUSH (1 cycle) SHALL add the final pair, compute activations, go to OUT with lane=0.
REQ-030 Activation: p = clamp(32768 + (acc >>> 8), 0, 65535) (hard sigmoid 0.5+x/4).
REQ-031 sample_en=1: p_data = 65535 if p > lfsr else 0; 16-bit Fibonacci LFSR taps 16,14,13,11, advances once per accepted output only.
REQ-032 OUT SHALL present p_valid=1, p_idx=g*LANES+lane; p_data/p_idx SHALL hold stable until p_valid&&p_ready.
REQ-033 On handshake: lane<LANES-1 -> lane+1; else if g<last -> g+1, BIAS; else -> IDLE with done=1 that cycle+1 (single pulse).
REQ-034 Latency start->first p_valid SHALL be I_DIM+2 cycles; per group, I_DIM+1 cycles plus handshakes.
REQ-035 p_ready held low SHALL stall in OUT indefinitely with no address or LFSR change.

Reset
REQ-036 rst SHALL asynchronously force IDLE; busy, done, p_valid, p_data, p_idx, addresses, acc, counters = 0; LFSR = LFSR_SEED.
REQ-037 rst asserted mid-pass SHALL abandon the pass; no done pulse; next start restarts at g=0.

Verification
REQ-038 I_DIM=4,H_DIM=4,LANES=4, v=all 0x40(0.5), w=all 0x4000(0.5), b=0, sample_en=0 -> acc=4*2^20, p_data=32768+16384=49152 for idx 0..3, first p_valid at cycle 6 after start.
REQ-039 b=-(2^24) lane 0, v=w=0 -> p_data=0; b=+(2^24) -> 65535 (clamp both ends).
REQ-040 v=0x80, w=0x8000 all, I_DIM=256, ACC_W=24 -> acc saturates at 2^23-1, p_data=65535, no wrap.
REQ-041 H_DIM=8,LANES=4, p_ready toggling 1/0 -> p_idx 0..7 in order, each word stable while stalled, one done pulse.
REQ-042 sample_en=1, p=32768 fixed -> outputs only 0/65535, sequence matches reference LFSR from 16'hACE1.
REQ-043 rst pulsed in ACC of group 1, then start -> outputs restart at p_idx 0, LFSR reseeded, no spurious done.
